cc_rd_fill_rsp_rx: RTL and testbench
====================================

// Module: cc_rd_fill_rsp_rx
// PURPOSE
//  Master-side receiver for the CC_RD_FILL (5'd8) response packet. Consumes the AXIS word stream
//  arriving from the Aurora RX and checks the RSN against the issued CSN.
//  Checks the RC against the CC and its bitwise inverse; latches the 128-bit fill header.
//  Forwards the ADC data words to a downstream AXIS sink, checks the length against the header
//  burst count, and reports completion and status to the command sequencer.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  idle cycles with no accepted word before the packet is abandoned
//  TO_W            20         timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYCLES
// PORTS
//  clk            in   1    local clock
//  reset          in   1    asynchronous, active-high
//  start          in   1    one-cycle pulse: a CC_RD_FILL has been issued; arm the receiver
//  expected_csn   in   32   CSN of the issued command; sampled on start
//  expected_cc    in   5    CC of the issued command; sampled on start
//  rx_tdata       in   32   AXIS slave data from the Aurora RX
//  rx_tvalid      in   1    AXIS slave valid
//  rx_tlast       in   1    AXIS slave last
//  rx_tready      out  1    AXIS slave ready
//  m_tdata        out  32   AXIS master data, ADC words, to the data FIFO
//  m_tvalid       out  1    AXIS master valid
//  m_tlast        out  1    AXIS master last; marks the final packet word
//  m_tready       in   1    AXIS master ready
//  fill_header    out  128  header {w3,w2,w1,w0}; w0 is the first header word
//  header_valid   out  1    one-cycle pulse when fill_header has been loaded
//  busy           out  1    high from the cycle after start until done
//  done           out  1    one-cycle pulse: packet finished or abandoned
//  status         out  5    {timeout, len_err, bad_rc, remote_err, csn_err}; valid with done
//  data_sum       out  32   mod-2^32 sum of every forwarded ADC word; valid with done
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, fill_header 0.
//  Handshake: a word is accepted only on a cycle with rx_tvalid && rx_tready.
//  States, one-hot:
//   IDLE: rx_tready=0. On start, latch expected_csn/expected_cc, clear status, sum and
//     counters, then go to RSN.
//   RSN: rx_tready=1. On an accepted word, set csn_err if the word != expected_csn, then go to RC.
//     If tlast is on this word, set len_err and go to DONE.
//   RC: rx_tready=1. An accepted word == {27'd0,cc} goes to HDR.
//     A word == ~{27'd0,cc} sets remote_err; tlast is required on this word, otherwise set
//     len_err and go to DRAIN. With tlast, go to DONE.
//     Any other word sets bad_rc and goes to DRAIN, or to DONE if tlast is on the word.
//   HDR: rx_tready=1. Accept 4 words into a 2-bit index. On the 4th word, pulse header_valid.
//     Load words_left = {hdr[84:64]+21'd1, 2'b00}, 23-bit; this equals (B+2)*4 minus the
//     4 header words. Then go to DATA.
//     tlast on any header word sets len_err and goes to DONE.
//   DATA: pass-through with no register: m_tdata=rx_tdata, m_tvalid=rx_tvalid,
//     rx_tready=m_tready. m_tlast = rx_tlast || (words_left==1).
//     Each accepted word adds to data_sum and decrements words_left.
//     Correct termination: tlast arrives with words_left==1, then go to DONE.
//     tlast with words_left>1 sets len_err and goes to DONE.
//     words_left==1 without tlast sets len_err and goes to DRAIN.
//   DRAIN: rx_tready=1, m_tvalid=0. Discard words until an accepted tlast, then go to DONE.
//   DONE: for one cycle, pulse done and drive status and data_sum; then go to IDLE.
//  Timeout: the counter clears on start and on every accepted word, and counts in RSN, RC, HDR,
//   DATA and DRAIN. At TIMEOUT_CYCLES-1, set timeout and go to DONE. No drain in this case.
//  A start outside IDLE is ignored.
//  Words arriving in IDLE are not accepted; they stall upstream.
//  Reset mid-packet returns to IDLE immediately and no done pulse is issued.
//  busy = !IDLE && !DONE.
//  A header count of hdr[84:64]=21'h1FFFFF gives 2^23 words_left, which does not fit 23 bits.
//   Widen the sum to 24 bits; 23'd0 is not a legal loaded value.
// STRUCTURE
//  Shared package/include: CC_RD_FILL=5'd8, the status bit indices, and the state indices.
//  Sub-module: rsp_timeout_ctr, a parameterised clear/enable counter with a terminal-count pulse.
//  Everything else stays flat in this module.
// TESTING
//  1. Good packet: CSN=32'h1234, CC=8, B=2, then 12 data words 1..12 with tlast on the 12th
//     -> header_valid once; done with status=0 and data_sum=78; m_tlast on word 12.
//  2. Error response: RC=32'hFFFFFFF7 with tlast -> done, status=5'b00010, no m_tvalid.
//  3. CSN mismatch: RSN=32'h1235 with a good remainder -> status=5'b00001, data forwarded.
//  4. Short packet: B=2 with tlast on data word 8 -> status=5'b01000, done on the cycle after
//     word 8. Long packet: 14 words -> len_err, and words 13..14 are drained.
//  5. Backpressure: in DATA, toggle m_tready with a 50% random pattern -> no word lost or
//     duplicated, rx_tready==m_tready, and sum is correct.
//  6. Timeout and reset: stop after header word 2 -> done with status=5'b10000 after
//     TIMEOUT_CYCLES. Reset asserted mid-DATA -> IDLE with all outputs 0, and a new start works.

Source files
------------

// File: rtl/cc_rd_fill_rsp_rx_pkg.sv
// rtl/cc_rd_fill_rsp_rx_pkg.sv - shared constants and state encoding for the CC_RD_FILL response receiver
// Purpose: command code, status bit positions and one-hot state encoding used by cc_rd_fill_rsp_rx.
// Ports: none (package).
package cc_rd_fill_rsp_rx_pkg;

  localparam logic [4:0] CC_RD_FILL = 5'd8;

  // Bit positions inside status = {timeout, len_err, bad_rc, remote_err, csn_err}
  localparam int STAT_CSN_ERR    = 0;
  localparam int STAT_REMOTE_ERR = 1;
  localparam int STAT_BAD_RC     = 2;
  localparam int STAT_LEN_ERR    = 3;
  localparam int STAT_TIMEOUT    = 4;

  // One-hot state indices
  localparam int ST_IDLE  = 0;
  localparam int ST_RSN   = 1;
  localparam int ST_RC    = 2;
  localparam int ST_HDR   = 3;
  localparam int ST_DATA  = 4;
  localparam int ST_DRAIN = 5;
  localparam int ST_DONE  = 6;

  typedef enum logic [6:0] {
    S_IDLE  = 7'(1 << ST_IDLE),
    S_RSN   = 7'(1 << ST_RSN),
    S_RC    = 7'(1 << ST_RC),
    S_HDR   = 7'(1 << ST_HDR),
    S_DATA  = 7'(1 << ST_DATA),
    S_DRAIN = 7'(1 << ST_DRAIN),
    S_DONE  = 7'(1 << ST_DONE)
  } state_t;

endpackage

// File: rtl/cc_rd_fill_rsp_rx_timeout_ctr.sv
// rtl/cc_rd_fill_rsp_rx_timeout_ctr.sv - clear/enable idle counter with terminal-count pulse
// Purpose: counts enabled cycles since the last clear; tc_o is high on the cycle the count
//   sits at TERMINAL while enabled and not being cleared.
// Ports: clk_i, rst_i (async, active-high), clr_i (sync clear), en_i (count enable), tc_o.
module rsp_timeout_ctr #(
  parameter int W        = 20,
  parameter int TERMINAL = 999_999
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A clear in the same cycle means a word was accepted, so no timeout.
  assign tc_o = en_i && !clr_i && (cnt_q == W'(TERMINAL));

endmodule

// File: rtl/cc_rd_fill_rsp_rx.sv
// rtl/cc_rd_fill_rsp_rx.sv - master-side receiver for the CC_RD_FILL response packet
// Purpose: checks RSN against the issued CSN and RC against the CC, latches the 128-bit fill
//   header, forwards ADC words downstream, checks packet length against the header burst count
//   and reports status/sum with a one-cycle done pulse.
// Ports: clk, reset (async, active-high); start/expected_csn/expected_cc arm the receiver;
//   rx_* AXIS slave from Aurora RX; m_* AXIS master to the data FIFO; fill_header/header_valid;
//   busy, done, status, data_sum to the command sequencer.
module cc_rd_fill_rsp_rx
  import cc_rd_fill_rsp_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_W           = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  expected_csn,
  input  logic [4:0]   expected_cc,
  input  logic [31:0]  rx_tdata,
  input  logic         rx_tvalid,
  input  logic         rx_tlast,
  output logic         rx_tready,
  output logic [31:0]  m_tdata,
  output logic         m_tvalid,
  output logic         m_tlast,
  input  logic         m_tready,
  output logic [127:0] fill_header,
  output logic         header_valid,
  output logic         busy,
  output logic         done,
  output logic [4:0]   status,
  output logic [31:0]  data_sum
);

  state_t         state_q, state_d;
  logic [31:0]    csn_q;
  logic [4:0]     cc_q;
  logic [4:0]     status_q, status_d;
  logic [31:0]    sum_q, sum_d;
  logic [23:0]    wl_q, wl_d;       // 24 bits: a count of 21'h1FFFFF loads 2^23
  logic [1:0]     hidx_q, hidx_d;
  logic [127:0]   hdr_q, hdr_d;
  logic           hv_q, hv_d;
  logic           accept, to_en, to_clr, to_tc;
  logic           in_data;

  assign in_data = (state_q == S_DATA);
  assign to_en   = (state_q == S_RSN) || (state_q == S_RC) || (state_q == S_HDR) ||
                   in_data || (state_q == S_DRAIN);
  assign busy    = to_en;
  assign done    = (state_q == S_DONE);

  // DATA is a straight pass-through, so upstream ready follows downstream ready.
  assign rx_tready = (state_q == S_RSN) || (state_q == S_RC) || (state_q == S_HDR) ||
                     (state_q == S_DRAIN) || (in_data && m_tready);
  assign accept    = rx_tvalid && rx_tready;
  assign m_tvalid  = in_data && rx_tvalid;
  assign m_tdata   = in_data ? rx_tdata : 32'd0;
  assign m_tlast   = in_data && (rx_tlast || (wl_q == 24'd1));

  assign fill_header  = hdr_q;
  assign header_valid = hv_q;
  assign status       = done ? status_q : 5'd0;
  assign data_sum     = done ? sum_q : 32'd0;

  assign to_clr = (start && state_q == S_IDLE) || accept;

  rsp_timeout_ctr #(
    .W        (TO_W),
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_timeout (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (to_clr),
    .en_i  (to_en),
    .tc_o  (to_tc)
  );

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    sum_d    = sum_q;
    wl_d     = wl_q;
    hidx_d   = hidx_q;
    hdr_d    = hdr_q;
    hv_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          status_d = '0;
          sum_d    = '0;
          wl_d     = '0;
          hidx_d   = '0;
          state_d  = S_RSN;
        end
      end
      S_RSN: begin
        if (accept) begin
          if (rx_tdata != csn_q) status_d[STAT_CSN_ERR] = 1'b1;
          if (rx_tlast) begin
            status_d[STAT_LEN_ERR] = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RC;
          end
        end
      end
      S_RC: begin
        if (accept) begin
          if (rx_tdata == {27'd0, cc_q}) begin
            if (rx_tlast) begin
              status_d[STAT_LEN_ERR] = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_HDR;
            end
          end else if (rx_tdata == ~{27'd0, cc_q}) begin
            // Remote error response must end right here.
            status_d[STAT_REMOTE_ERR] = 1'b1;
            if (rx_tlast) begin
              state_d = S_DONE;
            end else begin
              status_d[STAT_LEN_ERR] = 1'b1;
              state_d = S_DRAIN;
            end
          end else begin
            status_d[STAT_BAD_RC] = 1'b1;
            state_d = rx_tlast ? S_DONE : S_DRAIN;
          end
        end
      end
      S_HDR: begin
        if (accept) begin
          hdr_d[{hidx_q, 5'd0} +: 32] = rx_tdata;
          hidx_d = hidx_q + 2'd1;
          if (hidx_q == 2'd3) begin
            hv_d = 1'b1;
            // (B+1)*4 data words follow; B sits in header bits 84:64 (word 2).
            wl_d = ({3'd0, hdr_q[84:64]} + 24'd1) << 2;
          end
          if (rx_tlast) begin
            status_d[STAT_LEN_ERR] = 1'b1;
            state_d = S_DONE;
          end else if (hidx_q == 2'd3) begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          sum_d = sum_q + rx_tdata;
          wl_d  = wl_q - 24'd1;
          if (rx_tlast) begin
            if (wl_q != 24'd1) status_d[STAT_LEN_ERR] = 1'b1;
            state_d = S_DONE;
          end else if (wl_q == 24'd1) begin
            status_d[STAT_LEN_ERR] = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (accept && rx_tlast) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Timeout wins only when nothing was accepted this cycle (tc is gated by clear).
    if (to_tc) begin
      status_d[STAT_TIMEOUT] = 1'b1;
      state_d = S_DONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      csn_q    <= '0;
      cc_q     <= '0;
      status_q <= '0;
      sum_q    <= '0;
      wl_q     <= '0;
      hidx_q   <= '0;
      hdr_q    <= '0;
      hv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      sum_q    <= sum_d;
      wl_q     <= wl_d;
      hidx_q   <= hidx_d;
      hdr_q    <= hdr_d;
      hv_q     <= hv_d;
      if (state_q == S_IDLE && start) begin
        csn_q <= expected_csn;
        cc_q  <= expected_cc;
      end
    end
  end

endmodule

// File: tb/tb_cc_rd_fill_rsp_rx.sv
// tb/tb_cc_rd_fill_rsp_rx.sv - scoreboard bench for cc_rd_fill_rsp_rx
module tb_cc_rd_fill_rsp_rx;

  localparam int TO = 40;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  expected_csn = '0;
  logic [4:0]   expected_cc = '0;
  logic [31:0]  rx_tdata = '0;
  logic         rx_tvalid = 1'b0;
  logic         rx_tlast = 1'b0;
  logic         rx_tready;
  logic [31:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready = 1'b1;
  logic [127:0] fill_header;
  logic         header_valid;
  logic         busy;
  logic         done;
  logic [4:0]   status;
  logic [31:0]  data_sum;

  int errors = 0;
  int checks = 0;
  logic bp_en = 1'b0;

  logic [32:0]  exp_data[$];   // {last, data}
  logic [36:0]  exp_done[$];   // {status, sum}
  logic [127:0] exp_hdr[$];

  always #5 clk = ~clk;

  cc_rd_fill_rsp_rx #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .expected_csn(expected_csn), .expected_cc(expected_cc),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tready(rx_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .fill_header(fill_header), .header_valid(header_valid),
    .busy(busy), .done(done), .status(status), .data_sum(data_sum)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (m_tvalid) begin
        chk("rx_tready_follows_m_tready", 128'(rx_tready), 128'(m_tready));
        if (m_tready) begin
          if (exp_data.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_data: got %0h last %0b expected none", m_tdata, m_tlast);
          end else begin
            chk("data_word", 128'({m_tlast, m_tdata}), 128'(exp_data.pop_front()));
          end
        end
      end
      if (header_valid) begin
        if (exp_hdr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_header: got %0h expected none", fill_header);
        end else begin
          chk("fill_header", fill_header, exp_hdr.pop_front());
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got status %0b sum %0d expected none", status, data_sum);
        end else begin
          chk("done_status_sum", 128'({status, data_sum}), 128'(exp_done.pop_front()));
        end
      end
    end
  end

  // Downstream ready: random 50% pattern when backpressure is enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [31:0] csn);
    start = 1'b1;
    expected_csn = csn;
    expected_cc = 5'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    bit ok = 0;
    rx_tdata = d;
    rx_tlast = last;
    rx_tvalid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rx_tready) begin ok = 1; break; end
    end
    @(posedge clk);
    #1;
    rx_tvalid = 1'b0;
    rx_tlast = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_stall: word %0h got no ready expected ready within 500 cycles", d);
    end
  endtask

  task automatic send_hdr(input logic [20:0] b);
    logic [31:0] w2;
    w2 = 32'hABC0_0000 | {11'd0, b};
    exp_hdr.push_back({32'h4444_0003, w2, 32'h2222_0001, 32'hF111_0000});
    send(32'hF111_0000, 0);
    send(32'h2222_0001, 0);
    send(w2, 0);
    send(32'h4444_0003, 0);
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    @(posedge clk);
    #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_done: got no done expected done within 200 cycles");
    end
  endtask

  task automatic good_packet();
    do_start(32'h1234);
    send(32'h1234, 0);
    send(32'h8, 0);
    send_hdr(21'd2);
    for (int i = 1; i <= 12; i++) exp_data.push_back({(i == 12), 32'(i)});
    exp_done.push_back({5'b00000, 32'd78});
    for (int i = 1; i <= 12; i++) send(32'(i), (i == 12));
    wait_done();
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_outputs", 128'({done, rx_tready, m_tvalid, m_tlast, header_valid, status, data_sum, m_tdata}), 128'(0));
    chk("reset_header", fill_header, 128'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    rx_tvalid = 1'b1;
    rx_tdata = 32'h77;
    @(negedge clk);
    chk("idle_not_ready", 128'(rx_tready), 128'(0));
    rx_tvalid = 1'b0;
    @(posedge clk);
    #1;

    // 1. good packet
    good_packet();

    // 2. remote error response
    do_start(32'h1234);
    chk("busy_after_start", 128'(busy), 128'(1));
    exp_done.push_back({5'b00010, 32'd0});
    send(32'h1234, 0);
    send(32'hFFFF_FFF7, 1);
    wait_done();

    // bad RC without tlast: drained
    do_start(32'h1234);
    exp_done.push_back({5'b00100, 32'd0});
    send(32'h1234, 0);
    send(32'h5, 0);
    send(32'hDEAD, 0);
    send(32'hBEEF, 1);
    wait_done();

    // 3. CSN mismatch, data still forwarded
    do_start(32'h1234);
    send(32'h1235, 0);
    send(32'h8, 0);
    send_hdr(21'd2);
    for (int i = 1; i <= 12; i++) exp_data.push_back({(i == 12), 32'(i)});
    exp_done.push_back({5'b00001, 32'd78});
    for (int i = 1; i <= 12; i++) send(32'(i), (i == 12));
    wait_done();

    // 4a. short packet: tlast on data word 8
    do_start(32'h1234);
    send(32'h1234, 0);
    send(32'h8, 0);
    send_hdr(21'd2);
    for (int i = 1; i <= 8; i++) exp_data.push_back({(i == 8), 32'(i)});
    exp_done.push_back({5'b01000, 32'd36});
    for (int i = 1; i <= 8; i++) send(32'(i), (i == 8));
    chk("short_done_next_cycle", 128'(done), 128'(1));
    wait_done();

    // 4b. long packet: 14 words, 13..14 drained
    do_start(32'h1234);
    send(32'h1234, 0);
    send(32'h8, 0);
    send_hdr(21'd2);
    for (int i = 1; i <= 12; i++) exp_data.push_back({(i == 12), 32'(i)});
    exp_done.push_back({5'b01000, 32'd78});
    for (int i = 1; i <= 14; i++) send(32'(i), (i == 14));
    wait_done();

    // 5. backpressure: words 0x101..0x10C, sum 3150
    do_start(32'h1234);
    send(32'h1234, 0);
    send(32'h8, 0);
    send_hdr(21'd2);
    bp_en = 1'b1;
    for (int i = 1; i <= 12; i++) exp_data.push_back({(i == 12), 32'h100 + 32'(i)});
    exp_done.push_back({5'b00000, 32'd3150});
    for (int i = 1; i <= 12; i++) send(32'h100 + 32'(i), (i == 12));
    wait_done();
    bp_en = 1'b0;
    @(posedge clk);
    #1;

    // 6a. timeout after header word 2
    do_start(32'h1234);
    send(32'h1234, 0);
    send(32'h8, 0);
    exp_done.push_back({5'b10000, 32'd0});
    send(32'hF111_0000, 0);
    send(32'h2222_0001, 0);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    chk("timeout_latency", 128'(n), 128'(TO));
    @(posedge clk);
    #1;

    // 6b. reset mid-DATA, then a fresh packet
    do_start(32'h1234);
    send(32'h1234, 0);
    send(32'h8, 0);
    send_hdr(21'd2);
    for (int i = 1; i <= 3; i++) exp_data.push_back({1'b0, 32'(i)});
    for (int i = 1; i <= 3; i++) send(32'(i), 0);
    chk("busy_in_data", 128'(busy), 128'(1));
    #3;
    reset = 1'b1;
    #1;
    chk("midreset_busy", 128'(busy), 128'(0));
    chk("midreset_outputs", 128'({done, rx_tready, m_tvalid, m_tlast, header_valid, status, data_sum, m_tdata}), 128'(0));
    chk("midreset_header", fill_header, 128'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    good_packet();

    repeat (3) @(posedge clk);
    chk("leftover_data", 128'(exp_data.size()), 128'(0));
    chk("leftover_done", 128'(exp_done.size()), 128'(0));
    chk("leftover_hdr", 128'(exp_hdr.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
